// File: rtl/hazard_unit.sv
// hazard_unit: pipeline hazard controller for the 5-stage ARM core.
// Tracks in-flight destination registers in a 3-entry scoreboard (EX, MEM, WB),
// drives stall/flush controls and ID-stage operand forwarding selects, and
// keeps a saturating count of stall cycles.
// Build option: define HAZARD_FORWARDING_EN to enable operand forwarding
// (only load-use stalls); leave it undefined to stall on every dependency.
module hazard_unit #(
  parameter int REG_W       = 4,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   id_valid,
  input  logic [REG_W-1:0]       id_rn,
  input  logic [REG_W-1:0]       id_rm,
  input  logic [REG_W-1:0]       id_rd,
  input  logic                   id_use_rn,
  input  logic                   id_use_rm,
  input  logic                   id_use_rd,
  input  logic                   id_reg_write,
  input  logic                   id_mem_to_reg,
  input  logic                   id_pc_src,
  output logic                   pc_enable,
  output logic                   if_id_enable,
  output logic                   if_id_flush,
  output logic                   nop_select,
  output logic [1:0]             fwd_a_sel,
  output logic [1:0]             fwd_b_sel,
  output logic [1:0]             fwd_c_sel,
  output logic [STALL_CNT_W-1:0] stall_count
);

  localparam logic [REG_W-1:0] PC_REG = REG_W'(15);

  // Scoreboard entries. Only EX keeps the load flag: a MEM or WB producer can
  // always be forwarded, whether its value came from the ALU or from memory.
  logic             ex_valid, ex_reg_write, ex_mem_to_reg;
  logic [REG_W-1:0] ex_rd;
  logic             mem_valid, mem_reg_write;
  logic [REG_W-1:0] mem_rd;
  logic             wb_valid, wb_reg_write;
  logic [REG_W-1:0] wb_rd;

  // Per-operand match vectors, bit 0 = Rn (A), bit 1 = Rm (B), bit 2 = Rd (C)
  logic [2:0] match_ex, match_mem, match_wb;
  logic       stall;
  logic [1:0] sel_a, sel_b, sel_c;

  // A source only matters if it is read, is not the PC, and the stage writes it
  function automatic logic src_hit(input logic v, input logic w,
                                   input logic [REG_W-1:0] rd,
                                   input logic [REG_W-1:0] r,
                                   input logic use_r);
    return v & w & (rd == r) & (r != PC_REG) & use_r;
  endfunction

  // Youngest producer wins; a load still in EX cannot be forwarded yet
  function automatic logic [1:0] pick_src(input logic hit_ex, input logic hit_mem,
                                          input logic hit_wb, input logic ex_load);
    if (hit_ex)       return ex_load ? 2'b00 : 2'b01;
    else if (hit_mem) return 2'b10;
    else if (hit_wb)  return 2'b11;
    else              return 2'b00;
  endfunction

  // Compare the ID operands against every scoreboard stage
  always_comb begin
    match_ex  = {3{id_valid}} &
                {src_hit(ex_valid, ex_reg_write, ex_rd, id_rd, id_use_rd),
                 src_hit(ex_valid, ex_reg_write, ex_rd, id_rm, id_use_rm),
                 src_hit(ex_valid, ex_reg_write, ex_rd, id_rn, id_use_rn)};
    match_mem = {3{id_valid}} &
                {src_hit(mem_valid, mem_reg_write, mem_rd, id_rd, id_use_rd),
                 src_hit(mem_valid, mem_reg_write, mem_rd, id_rm, id_use_rm),
                 src_hit(mem_valid, mem_reg_write, mem_rd, id_rn, id_use_rn)};
    match_wb  = {3{id_valid}} &
                {src_hit(wb_valid, wb_reg_write, wb_rd, id_rd, id_use_rd),
                 src_hit(wb_valid, wb_reg_write, wb_rd, id_rm, id_use_rm),
                 src_hit(wb_valid, wb_reg_write, wb_rd, id_rn, id_use_rn)};
  end

`ifdef HAZARD_FORWARDING_EN
  // Forwarding build: only a load feeding the very next instruction stalls
  always_comb begin
    stall = (|match_ex) & ex_mem_to_reg;
    sel_a = pick_src(match_ex[0], match_mem[0], match_wb[0], ex_mem_to_reg);
    sel_b = pick_src(match_ex[1], match_mem[1], match_wb[1], ex_mem_to_reg);
    sel_c = pick_src(match_ex[2], match_mem[2], match_wb[2], ex_mem_to_reg);
  end
`else
  // The load flag is irrelevant when every dependency waits for write-back
  logic unused_ex_load;
  assign unused_ex_load = ex_mem_to_reg;

  // No forwarding: hold ID until every producer of a used source has retired
  always_comb begin
    stall = |{match_ex, match_mem, match_wb};
    sel_a = 2'b00;
    sel_b = 2'b00;
    sel_c = 2'b00;
  end
`endif

  // Pipeline control outputs; reset forces the free-running, no-forward state
  always_comb begin
    pc_enable    = reset | ~stall;
    if_id_enable = reset | ~stall;
    nop_select   = ~reset & stall;
    if_id_flush  = ~reset & ~stall & id_valid & id_pc_src;
    fwd_a_sel    = reset ? 2'b00 : sel_a;
    fwd_b_sel    = reset ? 2'b00 : sel_b;
    fwd_c_sel    = reset ? 2'b00 : sel_c;
  end

  // Advance the scoreboard; a stalled or empty ID slot enters EX as a bubble
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid      <= 1'b0;
      ex_rd         <= '0;
      ex_reg_write  <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      mem_valid     <= 1'b0;
      mem_rd        <= '0;
      mem_reg_write <= 1'b0;
      wb_valid      <= 1'b0;
      wb_rd         <= '0;
      wb_reg_write  <= 1'b0;
    end else begin
      wb_valid      <= mem_valid;
      wb_rd         <= mem_rd;
      wb_reg_write  <= mem_reg_write;
      mem_valid     <= ex_valid;
      mem_rd        <= ex_rd;
      mem_reg_write <= ex_reg_write;
      if (id_valid && !stall) begin
        ex_valid      <= 1'b1;
        ex_rd         <= id_rd;
        ex_reg_write  <= id_reg_write;
        ex_mem_to_reg <= id_mem_to_reg;
      end else begin
        ex_valid      <= 1'b0;
        ex_rd         <= '0;
        ex_reg_write  <= 1'b0;
        ex_mem_to_reg <= 1'b0;
      end
    end
  end

  // Saturating stall-cycle counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count <= '0;
    end else if (stall && (stall_count != '1)) begin
      stall_count <= stall_count + STALL_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed bench for hazard_unit. Follows whichever
// HAZARD_FORWARDING_EN setting the design is built with. A second instance
// with a 2-bit stall counter covers counter saturation.
module tb_hazard_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid;
  logic [3:0] id_rn, id_rm, id_rd;
  logic       id_use_rn, id_use_rm, id_use_rd;
  logic       id_reg_write, id_mem_to_reg, id_pc_src;

  logic        pc_enable, if_id_enable, if_id_flush, nop_select;
  logic [1:0]  fwd_a_sel, fwd_b_sel, fwd_c_sel;
  logic [15:0] stall_count;

  logic       s_pc_enable, s_if_id_enable, s_if_id_flush, s_nop_select;
  logic [1:0] s_fwd_a_sel, s_fwd_b_sel, s_fwd_c_sel;
  logic [1:0] s_stall_count;

  int errors = 0;
  int checks = 0;
  int exp_cnt = 0;

  hazard_unit #(.REG_W(4), .STALL_CNT_W(16)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rn(id_rn), .id_rm(id_rm), .id_rd(id_rd),
    .id_use_rn(id_use_rn), .id_use_rm(id_use_rm), .id_use_rd(id_use_rd),
    .id_reg_write(id_reg_write), .id_mem_to_reg(id_mem_to_reg), .id_pc_src(id_pc_src),
    .pc_enable(pc_enable), .if_id_enable(if_id_enable), .if_id_flush(if_id_flush),
    .nop_select(nop_select), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .fwd_c_sel(fwd_c_sel), .stall_count(stall_count)
  );

  hazard_unit #(.REG_W(4), .STALL_CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rn(id_rn), .id_rm(id_rm), .id_rd(id_rd),
    .id_use_rn(id_use_rn), .id_use_rm(id_use_rm), .id_use_rd(id_use_rd),
    .id_reg_write(id_reg_write), .id_mem_to_reg(id_mem_to_reg), .id_pc_src(id_pc_src),
    .pc_enable(s_pc_enable), .if_id_enable(s_if_id_enable), .if_id_flush(s_if_id_flush),
    .nop_select(s_nop_select), .fwd_a_sel(s_fwd_a_sel), .fwd_b_sel(s_fwd_b_sel),
    .fwd_c_sel(s_fwd_c_sel), .stall_count(s_stall_count)
  );

  always #5 clk = ~clk;

  // Drive one ID-stage instruction
  task automatic applyStimulus(input logic v, input logic [3:0] rn, input logic [3:0] rm,
                               input logic [3:0] rd, input logic urn, input logic urm,
                               input logic urd, input logic rw, input logic m2r,
                               input logic br);
    id_valid      = v;
    id_rn         = rn;
    id_rm         = rm;
    id_rd         = rd;
    id_use_rn     = urn;
    id_use_rm     = urm;
    id_use_rd     = urd;
    id_reg_write  = rw;
    id_mem_to_reg = m2r;
    id_pc_src     = br;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset held with hazardous inputs
    reset = 1'b1;
    applyStimulus(1'b1, 4'd1, 4'd1, 4'd1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_pc_enable", 32'(pc_enable), 32'd1);
    checkOutput("rst_if_id_enable", 32'(if_id_enable), 32'd1);
    checkOutput("rst_flush", 32'(if_id_flush), 32'd0);
    checkOutput("rst_nop", 32'(nop_select), 32'd0);
    checkOutput("rst_fwd_a", 32'(fwd_a_sel), 32'd0);
    checkOutput("rst_count", 32'(stall_count), 32'd0);
    checkOutput("rst_sat_count", 32'(s_stall_count), 32'd0);
    idle();
    reset = 1'b0;
    tick();

    // ADD R5,R0,R3 then ADD R6,R5,R1
    $display("[TB] ALU dependency");
    applyStimulus(1'b1, 4'd0, 4'd3, 4'd5, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    #1;
    checkOutput("add1_pc_enable", 32'(pc_enable), 32'd1);
    tick();
    applyStimulus(1'b1, 4'd5, 4'd1, 4'd6, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    #1;
`ifdef HAZARD_FORWARDING_EN
    checkOutput("fwd_ex_a", 32'(fwd_a_sel), 32'd1);
    checkOutput("fwd_ex_b", 32'(fwd_b_sel), 32'd0);
    checkOutput("fwd_ex_pc_enable", 32'(pc_enable), 32'd1);
    checkOutput("fwd_ex_nop", 32'(nop_select), 32'd0);
    tick();
    applyStimulus(1'b1, 4'd5, 4'd2, 4'd7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    #1;
    checkOutput("fwd_mem_a", 32'(fwd_a_sel), 32'd2);
    checkOutput("fwd_mem_pc_enable", 32'(pc_enable), 32'd1);
    tick();
    applyStimulus(1'b1, 4'd6, 4'd5, 4'd8, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    #1;
    checkOutput("fwd_mix_a", 32'(fwd_a_sel), 32'd2);
    checkOutput("fwd_wb_b", 32'(fwd_b_sel), 32'd3);
    tick();
    applyStimulus(1'b0, 4'd8, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("invalid_fwd_a", 32'(fwd_a_sel), 32'd0);
    checkOutput("invalid_pc_enable", 32'(pc_enable), 32'd1);
`else
    checkOutput("nf_stall1_pc_enable", 32'(pc_enable), 32'd0);
    checkOutput("nf_stall1_if_id_enable", 32'(if_id_enable), 32'd0);
    checkOutput("nf_stall1_nop", 32'(nop_select), 32'd1);
    checkOutput("nf_stall1_fwd_a", 32'(fwd_a_sel), 32'd0);
    checkOutput("nf_stall1_count", 32'(stall_count), 32'd0);
    tick();
    checkOutput("nf_stall2_pc_enable", 32'(pc_enable), 32'd0);
    tick();
    checkOutput("nf_stall3_pc_enable", 32'(pc_enable), 32'd0);
    checkOutput("nf_stall3_count", 32'(stall_count), 32'd2);
    tick();
    checkOutput("nf_clear_pc_enable", 32'(pc_enable), 32'd1);
    checkOutput("nf_clear_nop", 32'(nop_select), 32'd0);
    checkOutput("nf_clear_fwd_a", 32'(fwd_a_sel), 32'd0);
    checkOutput("nf_clear_count", 32'(stall_count), 32'd3);
    exp_cnt = 3;
    tick();
    applyStimulus(1'b0, 4'd6, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("invalid_pc_enable", 32'(pc_enable), 32'd1);
`endif
    idle();
    repeat (3) tick();

    // LDRB R2,[R4] then STR R2,[R4]
    $display("[TB] load-use");
    applyStimulus(1'b1, 4'd4, 4'd0, 4'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    #1;
    checkOutput("ldrb_pc_enable", 32'(pc_enable), 32'd1);
    tick();
    applyStimulus(1'b1, 4'd4, 4'd0, 4'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("lu_pc_enable", 32'(pc_enable), 32'd0);
    checkOutput("lu_nop", 32'(nop_select), 32'd1);
    checkOutput("lu_count_before", 32'(stall_count), 32'(exp_cnt));
`ifdef HAZARD_FORWARDING_EN
    tick();
    exp_cnt += 1;
    checkOutput("lu_after_pc_enable", 32'(pc_enable), 32'd1);
    checkOutput("lu_after_nop", 32'(nop_select), 32'd0);
    checkOutput("lu_after_fwd_c", 32'(fwd_c_sel), 32'd2);
    checkOutput("lu_after_fwd_a", 32'(fwd_a_sel), 32'd0);
`else
    tick();
    checkOutput("nf_lu_mem_pc_enable", 32'(pc_enable), 32'd0);
    tick();
    checkOutput("nf_lu_wb_pc_enable", 32'(pc_enable), 32'd0);
    tick();
    exp_cnt += 3;
    checkOutput("nf_lu_after_pc_enable", 32'(pc_enable), 32'd1);
    checkOutput("nf_lu_after_fwd_c", 32'(fwd_c_sel), 32'd0);
`endif
    checkOutput("lu_count_after", 32'(stall_count), 32'(exp_cnt));
    tick();
    idle();
    repeat (3) tick();

    // Taken branch and R15 handling
    $display("[TB] branch and R15");
    applyStimulus(1'b1, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    #1;
    checkOutput("br_flush", 32'(if_id_flush), 32'd1);
    checkOutput("br_pc_enable", 32'(pc_enable), 32'd1);
    checkOutput("br_if_id_enable", 32'(if_id_enable), 32'd1);
    checkOutput("br_nop", 32'(nop_select), 32'd0);
    tick();
    applyStimulus(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    #1;
    checkOutput("br_bubble_flush", 32'(if_id_flush), 32'd0);
    applyStimulus(1'b1, 4'd0, 4'd0, 4'd15, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 4'd15, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("r15_pc_enable", 32'(pc_enable), 32'd1);
    checkOutput("r15_fwd_a", 32'(fwd_a_sel), 32'd0);
    tick();
    idle();
    repeat (3) tick();

    // LDR R3 followed by a taken branch that reads R3: stall beats flush
    applyStimulus(1'b1, 4'd0, 4'd0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b1, 4'd3, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    #1;
    checkOutput("brst_pc_enable", 32'(pc_enable), 32'd0);
    checkOutput("brst_flush", 32'(if_id_flush), 32'd0);
`ifdef HAZARD_FORWARDING_EN
    tick();
    exp_cnt += 1;
    checkOutput("brst_after_fwd_a", 32'(fwd_a_sel), 32'd2);
`else
    tick();
    checkOutput("nf_brst_mem_flush", 32'(if_id_flush), 32'd0);
    tick();
    tick();
    exp_cnt += 3;
    checkOutput("nf_brst_after_fwd_a", 32'(fwd_a_sel), 32'd0);
`endif
    checkOutput("brst_after_flush", 32'(if_id_flush), 32'd1);
    checkOutput("brst_after_pc_enable", 32'(pc_enable), 32'd1);
    checkOutput("brst_count", 32'(stall_count), 32'(exp_cnt));
    tick();
    idle();
    repeat (3) tick();

    // Counter saturation and reset in the middle of a stall
    $display("[TB] saturation and mid-stall reset");
    reset = 1'b1;
    #1;
    checkOutput("pulse_count", 32'(stall_count), 32'd0);
    tick();
    reset = 1'b0;
    applyStimulus(1'b1, 4'd1, 4'd0, 4'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
`ifdef HAZARD_FORWARDING_EN
    repeat (11) tick();
`else
    repeat (7) tick();
`endif
    checkOutput("sat_in_stall_pc_enable", 32'(pc_enable), 32'd0);
    checkOutput("sat_count_wide", 32'(stall_count), 32'd5);
    checkOutput("sat_count_narrow", 32'(s_stall_count), 32'd3);
    reset = 1'b1;
    #1;
    checkOutput("midrst_pc_enable", 32'(pc_enable), 32'd1);
    checkOutput("midrst_if_id_enable", 32'(if_id_enable), 32'd1);
    checkOutput("midrst_nop", 32'(nop_select), 32'd0);
    checkOutput("midrst_count", 32'(stall_count), 32'd0);
    checkOutput("midrst_sat_count", 32'(s_stall_count), 32'd0);
    tick();
    reset = 1'b0;
    #1;
    checkOutput("postrst_pc_enable", 32'(pc_enable), 32'd1);
    tick();
    checkOutput("postrst_count", 32'(stall_count), 32'd0);
    checkOutput("postrst_restall_pc_enable", 32'(pc_enable), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
